// File: rtl/card_table_buffer.sv
// Double-buffered card-slot table between the CPU store bus and the VGA reader; shadow commits to display at frame_end.
// Optional CARD_TABLE_STATS_EN adds stats[15:0] = {dropped-store count, commit count}.
module card_table_buffer #(
  parameter int unsigned NUM_SLOTS  = 10,
  parameter int unsigned BASE_ADDR  = 16,
  parameter int unsigned WL_ADDR    = 15,
  parameter int unsigned CLR_ADDR   = 14,
  parameter int unsigned IDX_WIDTH  = 6,
  parameter int unsigned MAX_CARD   = 52,
  parameter int unsigned EMPTY_CODE = 63
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_we,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic        frame_end,
  input  logic [31:0] rd_addr,
  output logic [31:0] rd_data,
  output logic [1:0]  win_loss,
  output logic        busy,
  output logic        dirty
`ifdef CARD_TABLE_STATS_EN
  ,
  output logic [15:0] stats
`endif
);

  localparam int unsigned PW = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  localparam logic [IDX_WIDTH-1:0] EMPTY = IDX_WIDTH'(EMPTY_CODE);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t               state_q, state_d;
  logic [PW-1:0]        ptr_q, ptr_d;
  logic [IDX_WIDTH-1:0] shadow_q [NUM_SLOTS];
  logic [IDX_WIDTH-1:0] shadow_d [NUM_SLOTS];
  logic [IDX_WIDTH-1:0] disp_q   [NUM_SLOTS];
  logic [IDX_WIDTH-1:0] disp_d   [NUM_SLOTS];
  logic [1:0]           sh_wl_q, sh_wl_d, disp_wl_q, disp_wl_d;
  logic                 dirty_q, dirty_d;
  logic [IDX_WIDTH-1:0] rd_q, rd_d;

  logic [31:0]          wr_off, rd_off;
  logic                 slot_we, wl_we, clr_we, commit;
  logic [IDX_WIDTH-1:0] card;
  logic [1:0]           wl_val;

  // Unsigned wrap makes the single "< NUM_SLOTS" test cover both window bounds.
  assign wr_off  = mem_addr - BASE_ADDR;
  assign rd_off  = rd_addr - BASE_ADDR;
  assign slot_we = mem_we && (wr_off < NUM_SLOTS);
  assign wl_we   = mem_we && (mem_addr == WL_ADDR);
  assign clr_we  = mem_we && (mem_addr == CLR_ADDR);
  assign card    = (mem_wdata <= MAX_CARD) ? mem_wdata[IDX_WIDTH-1:0] : EMPTY;
  assign wl_val  = (mem_wdata[1:0] == 2'b11) ? 2'b00 : mem_wdata[1:0];
  assign commit  = frame_end && (state_q == IDLE) && dirty_q;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    if (clr_we) begin
      state_d = CLEAR;
      ptr_d   = '0;
    end else if (state_q == CLEAR) begin
      if (ptr_q == PW'(NUM_SLOTS - 1)) begin
        state_d = IDLE;
        ptr_d   = '0;
      end else begin
        ptr_d = ptr_q + 1'b1;
      end
    end
  end

  // Clear first, then the bus store, so a store hitting the pointer slot wins.
  always_comb begin
    rd_d = EMPTY;
    for (int k = 0; k < NUM_SLOTS; k++) begin
      shadow_d[k] = shadow_q[k];
      disp_d[k]   = commit ? shadow_q[k] : disp_q[k];
      if (state_q == CLEAR && ptr_q == PW'(k)) shadow_d[k] = EMPTY;
      if (slot_we && wr_off == 32'(k))         shadow_d[k] = card;
      if (rd_off == 32'(k))                    rd_d        = disp_q[k];
    end
    sh_wl_d = sh_wl_q;
    if (state_q == CLEAR && ptr_q == '0) sh_wl_d = 2'b00;
    if (wl_we)                           sh_wl_d = wl_val;
    disp_wl_d = commit ? sh_wl_q : disp_wl_q;
    dirty_d   = commit ? 1'b0 : dirty_q;
    if (slot_we || wl_we || clr_we) dirty_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      sh_wl_q   <= 2'b00;
      disp_wl_q <= 2'b00;
      dirty_q   <= 1'b0;
      rd_q      <= EMPTY;
      for (int k = 0; k < NUM_SLOTS; k++) begin
        shadow_q[k] <= EMPTY;
        disp_q[k]   <= EMPTY;
      end
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      sh_wl_q   <= sh_wl_d;
      disp_wl_q <= disp_wl_d;
      dirty_q   <= dirty_d;
      rd_q      <= rd_d;
      for (int k = 0; k < NUM_SLOTS; k++) begin
        shadow_q[k] <= shadow_d[k];
        disp_q[k]   <= disp_d[k];
      end
    end
  end

  assign rd_data  = {{(32-IDX_WIDTH){1'b0}}, rd_q};
  assign win_loss = disp_wl_q;
  assign busy     = (state_q == CLEAR);
  assign dirty    = dirty_q;

`ifdef CARD_TABLE_STATS_EN
  logic [7:0] ncommit_q, ncommit_d, ndrop_q, ndrop_d;
  logic       drop;

  // A store above the pointer lands now but the sweep will wipe it.
  assign drop = slot_we && (state_q == CLEAR) && (wr_off > 32'(ptr_q));

  always_comb begin
    ncommit_d = ncommit_q;
    ndrop_d   = ndrop_q;
    if (commit && ncommit_q != 8'hFF) ncommit_d = ncommit_q + 8'd1;
    if (drop && ndrop_q != 8'hFF)     ndrop_d   = ndrop_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      ncommit_q <= '0;
      ndrop_q   <= '0;
    end else begin
      ncommit_q <= ncommit_d;
      ndrop_q   <= ndrop_d;
    end
  end

  assign stats = {ndrop_q, ncommit_q};
`endif

endmodule

// File: tb/tb_card_table_buffer.sv
// Directed bench for card_table_buffer: vector table for the single-cycle behaviour, hand sequences for clear/reset.
module tb_card_table_buffer;

  logic        clk = 1'b0;
  logic        reset, mem_we, frame_end;
  logic [31:0] mem_addr, mem_wdata, rd_addr, rd_data;
  logic [1:0]  win_loss;
  logic        busy, dirty;
`ifdef CARD_TABLE_STATS_EN
  logic [15:0] stats;
`endif

  int checks = 0;
  int errors = 0;
  int exp_commits = 0;

  always #5 clk = ~clk;

  card_table_buffer dut (
    .clk(clk), .reset(reset), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .frame_end(frame_end), .rd_addr(rd_addr),
    .rd_data(rd_data), .win_loss(win_loss), .busy(busy), .dirty(dirty)
`ifdef CARD_TABLE_STATS_EN
    , .stats(stats)
`endif
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        fe;
    logic [31:0] ra;
    logic [31:0] rd;
    logic [1:0]  wl;
    logic        dt;
    logic        cm;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t v(input logic we, input logic [31:0] a, input logic [31:0] d,
                             input logic fe, input logic [31:0] ra, input logic [31:0] rd,
                             input logic [1:0] wl, input logic dt, input logic cm);
    vec_t r;
    r.we = we; r.addr = a; r.wdata = d; r.fe = fe; r.ra = ra;
    r.rd = rd; r.wl = wl; r.dt = dt; r.cm = cm;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Present one cycle of inputs, let the edge take them, then return to idle bus.
  task automatic step(input logic we, input logic [31:0] a, input logic [31:0] d,
                      input logic fe, input logic [31:0] ra);
    mem_we = we; mem_addr = a; mem_wdata = d; frame_end = fe; rd_addr = ra;
    tick();
    mem_we = 1'b0; frame_end = 1'b0;
  endtask

  task automatic read_slot(input int k, input logic [31:0] exp, input string tag);
    step(1'b0, 32'd0, 32'd0, 1'b0, 32'(16 + k));
    chk($sformatf("%s slot%0d", tag, k), rd_data, exp);
  endtask

  initial begin
    int busy_cnt;
    logic [31:0] e;
    reset = 1'b0; mem_we = 1'b0; mem_addr = '0; mem_wdata = '0; frame_end = 1'b0; rd_addr = '0;
    tick(); tick();
    chk("rst rd_data", rd_data, 32'd63);
    chk("rst win_loss", 32'(win_loss), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst dirty", 32'(dirty), 32'd0);
`ifdef CARD_TABLE_STATS_EN
    chk("rst stats", 32'(stats), 32'd0);
`endif
    reset = 1'b1;
    for (int k = 0; k < 10; k++) read_slot(k, 32'd63, "post-reset");

    //           we  addr wdata          fe  ra  rd  wl dt cm
    tv.push_back(v(0, 0,  0,             0,  16, 63, 0, 0, 0));
    tv.push_back(v(0, 0,  0,             0,  25, 63, 0, 0, 0));
    tv.push_back(v(1, 17, 5,             0,  17, 63, 0, 1, 0));
    tv.push_back(v(1, 19, 4,             0,  17, 63, 0, 1, 0));
    tv.push_back(v(0, 0,  0,             1,  17, 63, 0, 0, 1));
    tv.push_back(v(0, 0,  0,             0,  17, 5,  0, 0, 0));
    tv.push_back(v(1, 16, 52,            0,  99, 63, 0, 1, 0));
    tv.push_back(v(1, 19, 99,            0,  15, 63, 0, 1, 0));
    tv.push_back(v(1, 15, 3,             0,  16, 63, 0, 1, 0));
    tv.push_back(v(1, 15, 2,             0,  0,  63, 0, 1, 0));
    tv.push_back(v(0, 0,  0,             1,  19, 4,  2, 0, 1));
    tv.push_back(v(0, 0,  0,             0,  16, 52, 2, 0, 0));
    tv.push_back(v(0, 0,  0,             0,  19, 63, 2, 0, 0));
    tv.push_back(v(1, 26, 1,             0,  17, 5,  2, 0, 0));
    tv.push_back(v(1, 13, 1,             0,  25, 63, 2, 0, 0));
    tv.push_back(v(1, 17, 32'h45,        0,  0,  63, 2, 1, 0));
    tv.push_back(v(1, 18, 32'h0100_0005, 0,  0,  63, 2, 1, 0));
    tv.push_back(v(1, 25, 0,             0,  0,  63, 2, 1, 0));
    tv.push_back(v(1, 15, 3,             0,  0,  63, 2, 1, 0));
    tv.push_back(v(0, 0,  0,             1,  0,  63, 0, 0, 1));
    tv.push_back(v(0, 0,  0,             0,  17, 63, 0, 0, 0));
    tv.push_back(v(0, 0,  0,             0,  18, 63, 0, 0, 0));
    tv.push_back(v(0, 0,  0,             0,  25, 0,  0, 0, 0));
    tv.push_back(v(0, 0,  0,             0,  24, 63, 0, 0, 0));
    tv.push_back(v(0, 0,  0,             1,  16, 52, 0, 0, 0));
    tv.push_back(v(1, 20, 8,             0,  20, 63, 0, 1, 0));
    tv.push_back(v(1, 21, 9,             1,  20, 63, 0, 1, 1));
    tv.push_back(v(0, 0,  0,             0,  21, 63, 0, 1, 0));
    tv.push_back(v(0, 0,  0,             0,  20, 8,  0, 1, 0));
    tv.push_back(v(0, 0,  0,             1,  21, 63, 0, 0, 1));
    tv.push_back(v(0, 0,  0,             0,  21, 9,  0, 0, 0));

    foreach (tv[i]) begin
      step(tv[i].we, tv[i].addr, tv[i].wdata, tv[i].fe, tv[i].ra);
      if (tv[i].cm) exp_commits++;
      chk($sformatf("vec%0d rd_data", i), rd_data, tv[i].rd);
      chk($sformatf("vec%0d win_loss", i), 32'(win_loss), 32'(tv[i].wl));
      chk($sformatf("vec%0d dirty", i), 32'(dirty), 32'(tv[i].dt));
      chk($sformatf("vec%0d busy", i), 32'(busy), 32'd0);
    end
`ifdef CARD_TABLE_STATS_EN
    chk("table stats", 32'(stats), 32'(exp_commits));
`endif

    // Long hold without frame_end: display must not move.
    step(1'b1, 32'd18, 32'd12, 1'b0, 32'd0);
    repeat (1000) tick();
    step(1'b0, 32'd0, 32'd0, 1'b0, 32'd18);
    chk("hold rd18", rd_data, 32'd63);
    chk("hold dirty", 32'(dirty), 32'd1);
    step(1'b0, 32'd0, 32'd0, 1'b1, 32'd0);
    exp_commits++;
    step(1'b0, 32'd0, 32'd0, 1'b0, 32'd18);
    chk("hold commit rd18", rd_data, 32'd12);
    chk("hold commit dirty", 32'(dirty), 32'd0);

    // Clear sweep with stores above, on and below the pointer.
    for (int k = 0; k < 10; k++) step(1'b1, 32'(16 + k), 32'd7, 1'b0, 32'd0);
    step(1'b1, 32'd15, 32'd1, 1'b0, 32'd0);
    step(1'b0, 32'd0, 32'd0, 1'b1, 32'd0);
    exp_commits++;
    step(1'b0, 32'd0, 32'd0, 1'b0, 32'd16);
    chk("fill rd16", rd_data, 32'd7);
    chk("fill win_loss", 32'(win_loss), 32'd1);
    step(1'b1, 32'd14, 32'd0, 1'b0, 32'd16);
    chk("clr busy start", 32'(busy), 32'd1);
    busy_cnt = busy ? 1 : 0;
    for (int i = 0; i < 12; i++) begin
      mem_we = (i == 2 || i == 6 || i == 8);
      mem_addr = (i == 2) ? 32'd20 : (i == 6) ? 32'd22 : 32'd17;
      mem_wdata = (i == 2) ? 32'd9 : (i == 6) ? 32'd11 : 32'd3;
      frame_end = (i == 4);
      rd_addr = 32'd16;
      tick();
      mem_we = 1'b0; frame_end = 1'b0;
      if (busy) busy_cnt++;
      if (i == 5) begin
        chk("clr no-commit rd16", rd_data, 32'd7);
        chk("clr no-commit wl", 32'(win_loss), 32'd1);
        chk("clr dirty", 32'(dirty), 32'd1);
      end
    end
    chk("clr busy cycles", 32'(busy_cnt), 32'd10);
    step(1'b0, 32'd0, 32'd0, 1'b1, 32'd0);
    exp_commits++;
    chk("clr commit dirty", 32'(dirty), 32'd0);
    chk("clr commit wl", 32'(win_loss), 32'd0);
    for (int k = 0; k < 10; k++) begin
      e = (k == 1) ? 32'd3 : (k == 6) ? 32'd11 : 32'd63;
      read_slot(k, e, "after-clear");
    end
`ifdef CARD_TABLE_STATS_EN
    chk("clr stats", 32'(stats), {16'd0, 8'd1, 8'(exp_commits)});
`endif

    // Reset landing in the middle of a clear.
    step(1'b1, 32'd16, 32'd1, 1'b0, 32'd0);
    step(1'b0, 32'd0, 32'd0, 1'b1, 32'd0);
    step(1'b0, 32'd0, 32'd0, 1'b0, 32'd16);
    chk("pre-rst rd16", rd_data, 32'd1);
    step(1'b1, 32'd14, 32'd0, 1'b0, 32'd16);
    tick(); tick();
    chk("mid-clear busy", 32'(busy), 32'd1);
    reset = 1'b0;
    tick();
    chk("rst-clr busy", 32'(busy), 32'd0);
    chk("rst-clr dirty", 32'(dirty), 32'd0);
    chk("rst-clr rd_data", rd_data, 32'd63);
    chk("rst-clr wl", 32'(win_loss), 32'd0);
`ifdef CARD_TABLE_STATS_EN
    chk("rst-clr stats", 32'(stats), 32'd0);
`endif
    reset = 1'b1;
    tick();
    chk("rst-clr idle", 32'(busy), 32'd0);
    for (int k = 0; k < 10; k++) read_slot(k, 32'd63, "after-reset");
    step(1'b0, 32'd0, 32'd0, 1'b1, 32'd16);
    chk("clean fe dirty", 32'(dirty), 32'd0);
`ifdef CARD_TABLE_STATS_EN
    chk("clean fe stats", 32'(stats), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
